// File: rtl/ptw_pkg.sv
// Shared definitions for the ITLB page-table walker.
//   - walker FSM state encoding
//   - PTE field positions (V, L, PPN)
//   - VPN slice positions for the two walk levels (10/10 split, 4 KiB pages)
package ptw_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StL1,
    StL2,
    StResp
  } ptw_state_e;

  localparam int unsigned PTE_V_BIT   = 0;
  localparam int unsigned PTE_L_BIT   = 1;
  localparam int unsigned PTE_PPN_LSB = 12;

  // LSB of each VPN level inside the virtual address
  localparam int unsigned VPN1_LSB = 22;
  localparam int unsigned VPN0_LSB = 12;

endpackage

// File: rtl/ptw_l1_cache.sv
// One-entry cache of the most recent successful level-1 PTE lookup.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        clear the entry (wins over a same-cycle fill)
//   fill         write {vpn1, satp, base} and mark the entry valid
//   fill_vpn1    VPN[1] tag to store
//   fill_satp    root PPN tag to store
//   fill_base    next-level table PPN to store
//   lookup_vpn1  VPN[1] of the incoming request
//   lookup_satp  root PPN of the incoming request
//   hit          entry valid and both tags match
//   hit_base     cached next-level table PPN
module ptw_l1_cache #(
  parameter int unsigned PPN_WIDTH     = 8,
  parameter int unsigned VPN_LVL_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fill,
  input  logic [VPN_LVL_WIDTH-1:0] fill_vpn1,
  input  logic [PPN_WIDTH-1:0]     fill_satp,
  input  logic [PPN_WIDTH-1:0]     fill_base,
  input  logic [VPN_LVL_WIDTH-1:0] lookup_vpn1,
  input  logic [PPN_WIDTH-1:0]     lookup_satp,
  output logic                     hit,
  output logic [PPN_WIDTH-1:0]     hit_base
);

  logic                     valid_q;
  logic [VPN_LVL_WIDTH-1:0] tag_q;
  logic [PPN_WIDTH-1:0]     satp_q;
  logic [PPN_WIDTH-1:0]     base_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= '0;
      satp_q <= '0;
      base_q <= '0;
    end else if (fill) begin
      tag_q  <= fill_vpn1;
      satp_q <= fill_satp;
      base_q <= fill_base;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_vpn1) && (satp_q == lookup_satp);
  assign hit_base = base_q;

endmodule

// File: rtl/itlb_ptw.sv
// Two-level hardware page-table walker answering ITLB misses.
// Optional build macro: PTW_L1_CACHE_EN adds a one-entry level-1 PTE cache
// (ptw_l1_cache) so walks hitting the same VPN[1]/root skip the first read.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   ptw_req     translation request (level, held until serviced)
//   ptw_va      virtual address to translate
//   satp_ppn    root page-table PPN
//   ptw_flush   drop walker-internal cached state (cache build only)
//   ptw_valid   one-cycle completion pulse
//   ptw_pa      translated PPN (0 on fault), valid with ptw_valid
//   ptw_fault   page fault, only together with ptw_valid
//   mem_req     PTE read request, held until mem_valid
//   mem_addr    PTE byte address (registered)
//   mem_rdata   PTE read data
//   mem_valid   read data valid
module itlb_ptw
  import ptw_pkg::*;
#(
  parameter int unsigned VA_WIDTH          = 32,
  parameter int unsigned PC_BITS           = 20,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  parameter int unsigned PPN_WIDTH         = PC_BITS - PAGE_OFFSET_WIDTH,
  parameter int unsigned VPN_LVL_WIDTH     = 10,
  parameter int unsigned PTE_WIDTH         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ptw_req,
  input  logic [VA_WIDTH-1:0]  ptw_va,
  input  logic [PPN_WIDTH-1:0] satp_ppn,
  input  logic                 ptw_flush,
  output logic                 ptw_valid,
  output logic [PPN_WIDTH-1:0] ptw_pa,
  output logic                 ptw_fault,
  output logic                 mem_req,
  output logic [PC_BITS-1:0]   mem_addr,
  input  logic [PTE_WIDTH-1:0] mem_rdata,
  input  logic                 mem_valid
);

  ptw_state_e               state_q;
  logic [VPN_LVL_WIDTH-1:0] vpn1_q;
  logic [VPN_LVL_WIDTH-1:0] vpn0_q;
  logic                     valid_q;
  logic                     fault_q;
  logic [PPN_WIDTH-1:0]     ppn_q;
  logic                     mem_req_q;
  logic [PC_BITS-1:0]       mem_addr_q;

  logic [VPN_LVL_WIDTH-1:0] req_vpn1;
  logic [VPN_LVL_WIDTH-1:0] req_vpn0;
  logic                     pte_v;
  logic                     pte_l;
  logic [PPN_WIDTH-1:0]     pte_ppn;
  logic                     cache_hit;
  logic [PPN_WIDTH-1:0]     cache_base;
  logic                     unused_bits;

  assign req_vpn1 = ptw_va[VPN1_LSB +: VPN_LVL_WIDTH];
  assign req_vpn0 = ptw_va[VPN0_LSB +: VPN_LVL_WIDTH];
  assign pte_v    = mem_rdata[PTE_V_BIT];
  assign pte_l    = mem_rdata[PTE_L_BIT];
  assign pte_ppn  = mem_rdata[PTE_PPN_LSB +: PPN_WIDTH];

`ifdef PTW_L1_CACHE_EN
  // Root PPN captured at accept so a fill is tagged with the root actually walked.
  logic [PPN_WIDTH-1:0] satp_q;
  logic                 cache_fill;

  assign cache_fill = (state_q == StL1) && mem_valid && pte_v && !pte_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      satp_q <= '0;
    end else if (state_q == StIdle && ptw_req) begin
      satp_q <= satp_ppn;
    end
  end

  ptw_l1_cache #(
    .PPN_WIDTH    (PPN_WIDTH),
    .VPN_LVL_WIDTH(VPN_LVL_WIDTH)
  ) u_l1_cache (
    .clk        (clk),
    .rst        (rst),
    .flush      (ptw_flush),
    .fill       (cache_fill),
    .fill_vpn1  (vpn1_q),
    .fill_satp  (satp_q),
    .fill_base  (pte_ppn),
    .lookup_vpn1(req_vpn1),
    .lookup_satp(satp_ppn),
    .hit        (cache_hit),
    .hit_base   (cache_base)
  );

  assign unused_bits = ^{ptw_va[PAGE_OFFSET_WIDTH-1:0], mem_rdata};
`else
  assign cache_hit   = 1'b0;
  assign cache_base  = '0;
  assign unused_bits = ^{ptw_va[PAGE_OFFSET_WIDTH-1:0], mem_rdata, ptw_flush};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      vpn1_q     <= '0;
      vpn0_q     <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      ppn_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ptw_req) begin
            vpn1_q    <= req_vpn1;
            vpn0_q    <= req_vpn0;
            mem_req_q <= 1'b1;
            if (cache_hit) begin
              state_q    <= StL2;
              mem_addr_q <= {cache_base, req_vpn0, 2'b00};
            end else begin
              state_q    <= StL1;
              mem_addr_q <= {satp_ppn, req_vpn1, 2'b00};
            end
          end
        end
        StL1: begin
          if (mem_valid) begin
            // Leaf at level 1 would be a megapage, which is not supported.
            if (!pte_v || pte_l) begin
              state_q   <= StResp;
              mem_req_q <= 1'b0;
              valid_q   <= 1'b1;
              fault_q   <= 1'b1;
              ppn_q     <= '0;
            end else begin
              state_q    <= StL2;
              mem_addr_q <= {pte_ppn, vpn0_q, 2'b00};
            end
          end
        end
        StL2: begin
          if (mem_valid) begin
            state_q   <= StResp;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            if (!pte_v || !pte_l) begin
              fault_q <= 1'b1;
              ppn_q   <= '0;
            end else begin
              fault_q <= 1'b0;
              ppn_q   <= pte_ppn;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          fault_q <= 1'b0;
          ppn_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ptw_valid = valid_q;
  assign ptw_fault = fault_q;
  assign ptw_pa    = ppn_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_itlb_ptw.sv
// Self-checking bench for itlb_ptw: a memory responder with programmable wait
// states, an address scoreboard for PTE reads and a response scoreboard
// holding {ppn, fault, completion cycle} for every walk issued.
module tb_itlb_ptw;

  localparam logic [31:0] VA1 = 32'h0040_3123;
  localparam logic [31:0] VA2 = 32'h0040_5000;

  logic        clk;
  logic        rst;
  logic        ptw_req;
  logic [31:0] ptw_va;
  logic [7:0]  satp_ppn;
  logic        ptw_flush;
  logic        ptw_valid;
  logic [7:0]  ptw_pa;
  logic        ptw_fault;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  itlb_ptw dut (
    .clk      (clk),
    .rst      (rst),
    .ptw_req  (ptw_req),
    .ptw_va   (ptw_va),
    .satp_ppn (satp_ppn),
    .ptw_flush(ptw_flush),
    .ptw_valid(ptw_valid),
    .ptw_pa   (ptw_pa),
    .ptw_fault(ptw_fault),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  typedef struct {
    logic [7:0] pa;
    logic       fault;
    int         cyc;
  } resp_t;

  resp_t       resp_q[$];
  logic [19:0] addr_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  // Memory model controls
  int          mem_wait  = 0;
  logic        mem_force = 1'b0;
  logic        skip_hold = 1'b0;
  logic [31:0] l1_pte    = 32'h0002_0001;
  logic [31:0] l2_pte    = 32'h0005_5003;

  int          wcnt      = 0;
  logic        prev_wait = 1'b0;
  logic [19:0] prev_addr = '0;
  logic        prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_lookup(input logic [19:0] a);
    case (a)
      20'h10004: return l1_pte;
      20'h2000C: return l2_pte;
      20'h20014: return 32'h0006_6003;
      default:   return 32'h0;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory responder; also checks PTE addresses and hold behaviour.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (prev_wait && mem_req) check_eq("mem_addr_stable", {12'h0, mem_addr}, {12'h0, prev_addr});
      if (prev_wait && !skip_hold) check_eq("mem_req_held", {31'h0, mem_req}, 32'h1);
      if (mem_valid) wcnt = 0;
      if (mem_force) begin
        mem_valid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        prev_wait = 1'b0;
      end else if (mem_req) begin
        if (wcnt >= mem_wait) begin
          mem_valid = 1'b1;
          mem_rdata = mem_lookup(mem_addr);
          prev_wait = 1'b0;
          check_eq("addr_expected", {31'h0, addr_q.size() != 0}, 32'h1);
          if (addr_q.size() != 0) check_eq("mem_addr", {12'h0, mem_addr}, {12'h0, addr_q.pop_front()});
        end else begin
          mem_valid = 1'b0;
          wcnt++;
          prev_wait = 1'b1;
        end
      end else begin
        mem_valid = 1'b0;
        wcnt      = 0;
        prev_wait = 1'b0;
      end
      prev_addr = mem_addr;
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ptw_valid) begin
        check_eq("no_double_pulse", {31'h0, prev_valid}, 32'h0);
        check_eq("resp_expected", {31'h0, resp_q.size() != 0}, 32'h1);
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          check_eq("ptw_pa", {24'h0, ptw_pa}, {24'h0, e.pa});
          check_eq("ptw_fault", {31'h0, ptw_fault}, {31'h0, e.fault});
          check_eq("resp_cycle", cyc, e.cyc);
        end
      end
      prev_valid = ptw_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic flush_cache();
    @(negedge clk);
    ptw_flush = 1'b1;
    @(negedge clk);
    ptw_flush = 1'b0;
  endtask

  // Issue one request; the response is expected lat cycles after acceptance.
  task automatic start_walk(input logic [31:0] va, input logic [7:0] satp,
                            input logic [7:0] exp_pa, input logic exp_fault, input int lat);
    resp_t e;
    @(negedge clk);
    ptw_va   = va;
    satp_ppn = satp;
    ptw_req  = 1'b1;
    e.pa     = exp_pa;
    e.fault  = exp_fault;
    e.cyc    = cyc + lat;
    resp_q.push_back(e);
    @(negedge clk);
    ptw_req  = 1'b0;
    // Mid-walk input changes must not disturb the walk.
    ptw_va   = 32'hDEAD_BEEF;
    satp_ppn = 8'hEE;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((resp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("resp_drained", resp_q.size(), 0);
    check_eq("addr_drained", addr_q.size(), 0);
  endtask

  initial begin
    resp_t e;
    int    c;
    rst       = 1'b1;
    ptw_req   = 1'b0;
    ptw_va    = '0;
    satp_ppn  = '0;
    ptw_flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", {31'h0, ptw_valid}, 32'h0);
    check_eq("rst_fault", {31'h0, ptw_fault}, 32'h0);
    check_eq("rst_pa", {24'h0, ptw_pa}, 32'h0);
    check_eq("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_mem_addr", {12'h0, mem_addr}, 32'h0);

    // Successful walk, zero-wait memory
    flush_cache();
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h2000C);
    start_walk(VA1, 8'h10, 8'h55, 1'b0, 3);
    wait_done(40);

    // Invalid L1 PTE
    flush_cache();
    l1_pte = 32'h0002_0000;
    addr_q.push_back(20'h10004);
    start_walk(VA1, 8'h10, 8'h00, 1'b1, 2);
    wait_done(40);

    // Leaf at L1 (megapage) faults
    l1_pte = 32'h0002_0003;
    addr_q.push_back(20'h10004);
    start_walk(VA1, 8'h10, 8'h00, 1'b1, 2);
    wait_done(40);
    l1_pte = 32'h0002_0001;

    // Non-leaf L2 PTE faults
    flush_cache();
    l2_pte = 32'h0005_5001;
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h2000C);
    start_walk(VA1, 8'h10, 8'h00, 1'b1, 3);
    wait_done(40);
    l2_pte = 32'h0005_5003;

    // Three wait states per read
    flush_cache();
    mem_wait = 3;
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h2000C);
    start_walk(VA1, 8'h10, 8'h55, 1'b0, 9);
    wait_done(40);
    mem_wait = 0;

    // Reset during the L2 wait, then a stray mem_valid
    flush_cache();
    mem_wait  = 5;
    skip_hold = 1'b1;
    addr_q.push_back(20'h10004);
    @(negedge clk);
    ptw_va   = VA1;
    satp_ppn = 8'h10;
    ptw_req  = 1'b1;
    @(negedge clk);
    ptw_req = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
    check_eq("pre_rst_mem_addr", {12'h0, mem_addr}, 32'h2000C);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("post_rst_mem_req", {31'h0, mem_req}, 32'h0);
    mem_force = 1'b1;
    repeat (3) @(negedge clk);
    mem_force = 1'b0;
    check_eq("stray_valid_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("stray_valid_addr_q", addr_q.size(), 0);
    skip_hold = 1'b0;
    mem_wait  = 0;
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h2000C);
    start_walk(VA1, 8'h10, 8'h55, 1'b0, 3);
    wait_done(40);

    // Back-to-back: request held through RESP; flush held throughout
    ptw_flush = 1'b1;
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h2000C);
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h20014);
    @(negedge clk);
    ptw_va   = VA1;
    satp_ppn = 8'h10;
    ptw_req  = 1'b1;
    c        = cyc;
    e.pa     = 8'h55;
    e.fault  = 1'b0;
    e.cyc    = c + 3;
    resp_q.push_back(e);
    e.pa     = 8'h66;
    e.cyc    = c + 7;
    resp_q.push_back(e);
    @(negedge clk);
    ptw_va = VA2;
    repeat (4) @(negedge clk);
    ptw_req = 1'b0;
    wait_done(40);
    ptw_flush = 1'b0;

`ifdef PTW_L1_CACHE_EN
    // Second walk under the same VPN[1] skips the L1 read; flush restores it
    flush_cache();
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h2000C);
    start_walk(VA1, 8'h10, 8'h55, 1'b0, 3);
    wait_done(40);
    addr_q.push_back(20'h20014);
    start_walk(VA2, 8'h10, 8'h66, 1'b0, 2);
    wait_done(40);
    flush_cache();
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h20014);
    start_walk(VA2, 8'h10, 8'h66, 1'b0, 3);
    wait_done(40);
`else
    // Without the cache, a repeat walk under the same VPN[1] still reads L1
    addr_q.push_back(20'h10004);
    addr_q.push_back(20'h20014);
    start_walk(VA2, 8'h10, 8'h66, 1'b0, 3);
    wait_done(40);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
